counter_timer3: RTL and testbench

//  Three-channel 32-bit programmable down-counter peripheral behind MIO_BUS.
//  - Loaded through the SPIO channel-select path (counter_set) and the counter_we/CPU2IO write path.
//  - counter0_out drives the CPU INT input.
//  - counter_out returns a selected channel's live count to the bus read mux.
//  - Count ticks come from clk_div taps (Div[8], Div[9], Div[10]); they are sampled in the clk domain.

---
 rtl/counter_timer3.sv | 225 ++++++++++++++++++++++
 tb/tb_counter_timer3.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/counter_timer3.sv
// -----------------------------------------------------------------------------
// counter_timer3 -- three-channel programmable down-counter peripheral.
//
// Each channel counts ticks taken from a slow tick source (rising edges of
// clk0/clk1/clk2, sampled in the clk domain). Channels run as ONE-SHOT, RATE,
// SQUARE or STOPPED. A bus write either reloads one channel or writes the
// control word, which holds the three modes and the readback select.
//
// Optional feature: define COUNTER_LATCH_EN to add a readback snapshot. A
// control write with val[31]=1 captures all three counts, and counter_out
// then shows the captured value until a control write with val[31]=0.
//
// Ports:
//   clk           system clock, all state updates on the rising edge
//   RSTN          synchronous active-low reset
//   clk0..clk2    tick sources for channels 0..2 (rising edge = one tick)
//   counter_we    one-cycle write strobe
//   counter_ch    write target: 0-2 channel reload, 3 control word
//   counter_val   write data
//   counter0_OUT  channel 0 output (CPU interrupt)
//   counter1_OUT  channel 1 output
//   counter2_OUT  channel 2 output
//   counter_out   registered count of the channel selected by rd_sel
// -----------------------------------------------------------------------------
module counter_timer3 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             RSTN,
   input  logic             clk0,
   input  logic             clk1,
   input  logic             clk2,
   input  logic             counter_we,
   input  logic [1:0]       counter_ch,
   input  logic [WIDTH-1:0] counter_val,
   output logic             counter0_OUT,
   output logic             counter1_OUT,
   output logic             counter2_OUT,
   output logic [WIDTH-1:0] counter_out
);

   typedef enum logic [1:0] {
      MODE_ONESHOT = 2'b00,
      MODE_RATE    = 2'b01,
      MODE_SQUARE  = 2'b10,
      MODE_STOP    = 2'b11
   } mode_t;

   localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [2:0]       tick_src_s;
   logic [2:0]       clk_d_r;
   logic [2:0]       tick_s;
   logic             ctrl_wr_s;

   logic [WIDTH-1:0] count_r      [3];
   logic [WIDTH-1:0] count_nxt_s  [3];
   logic [WIDTH-1:0] reload_r     [3];
   logic [WIDTH-1:0] reload_nxt_s [3];
   mode_t            mode_r       [3];
   mode_t            mode_nxt_s   [3];
   logic [2:0]       out_r;
   logic [2:0]       out_nxt_s;

   logic [1:0]       rd_sel_r;
   logic [1:0]       rd_sel_nxt_s;
   logic [1:0]       rd_idx_s;
   logic [WIDTH-1:0] read_val_s;
   logic [WIDTH-1:0] counter_out_r;

`ifdef COUNTER_LATCH_EN
   logic [WIDTH-1:0] latch_r [3];
   logic             latched_r;
   logic             unused_val_bits_s;
   assign unused_val_bits_s = ^counter_val[30:10];
`else
   logic             unused_val_bits_s;
   assign unused_val_bits_s = ^counter_val[31:10];
`endif

   assign tick_src_s = {clk2, clk1, clk0};
   // One tick per rising edge of each source; the registered copy holds the previous level.
   assign tick_s     = tick_src_s & ~clk_d_r;
   assign ctrl_wr_s  = counter_we & (counter_ch == 2'd3);

   // Readback index: rd_sel=3 aliases channel 0.
   assign rd_idx_s = (rd_sel_r == 2'd3) ? 2'd0 : rd_sel_r;

   // Next-state for every channel: writes take priority and swallow same-cycle ticks.
   always_comb begin
      if (ctrl_wr_s) begin
         rd_sel_nxt_s = counter_val[9:8];
      end else begin
         rd_sel_nxt_s = rd_sel_r;
      end

      for (int i = 0; i < 3; i++) begin
         count_nxt_s[i]  = count_r[i];
         reload_nxt_s[i] = reload_r[i];
         mode_nxt_s[i]   = mode_r[i];
         // A RATE pulse lasts exactly one cycle, tick or not.
         out_nxt_s[i]    = (mode_r[i] == MODE_RATE) ? 1'b0 : out_r[i];

         if (counter_we && (counter_ch == 2'(i))) begin
            count_nxt_s[i]  = counter_val;
            reload_nxt_s[i] = counter_val;
            out_nxt_s[i]    = 1'b0;
         end else if (ctrl_wr_s) begin
            mode_nxt_s[i] = mode_t'(counter_val[2*i +: 2]);
            out_nxt_s[i]  = 1'b0;
         end else if (tick_s[i]) begin
            case (mode_r[i])
               MODE_ONESHOT: begin
                  if (count_r[i] > CNT_ONE) begin
                     count_nxt_s[i] = count_r[i] - CNT_ONE;
                  end else if (count_r[i] == CNT_ONE) begin
                     count_nxt_s[i] = CNT_ZERO;
                     out_nxt_s[i]   = 1'b1;
                  end else begin
                     count_nxt_s[i] = count_r[i];
                  end
               end
               MODE_RATE: begin
                  if (count_r[i] > CNT_ONE) begin
                     count_nxt_s[i] = count_r[i] - CNT_ONE;
                  end else if (count_r[i] == CNT_ONE) begin
                     count_nxt_s[i] = reload_r[i];
                     out_nxt_s[i]   = 1'b1;
                  end else begin
                     count_nxt_s[i] = reload_r[i];
                  end
               end
               MODE_SQUARE: begin
                  if (reload_r[i] == CNT_ZERO) begin
                     count_nxt_s[i] = count_r[i];
                  end else if (count_r[i] > CNT_ONE) begin
                     count_nxt_s[i] = count_r[i] - CNT_ONE;
                  end else if (count_r[i] == CNT_ONE) begin
                     count_nxt_s[i] = reload_r[i];
                     out_nxt_s[i]   = ~out_r[i];
                  end else begin
                     // Count left at 0 by an earlier mode: restart the period.
                     count_nxt_s[i] = reload_r[i];
                  end
               end
               MODE_STOP: begin
                  count_nxt_s[i] = count_r[i];
               end
               default: begin
                  count_nxt_s[i] = count_r[i];
               end
            endcase
         end else begin
            count_nxt_s[i] = count_r[i];
         end
      end
   end

   // Readback source: live count, or the snapshot while one is held.
   always_comb begin
`ifdef COUNTER_LATCH_EN
      if (latched_r) begin
         read_val_s = latch_r[rd_idx_s];
      end else begin
         read_val_s = count_r[rd_idx_s];
      end
`else
      read_val_s = count_r[rd_idx_s];
`endif
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!RSTN) begin
         clk_d_r       <= 3'b000;
         out_r         <= 3'b000;
         rd_sel_r      <= 2'd0;
         counter_out_r <= CNT_ZERO;
         for (int i = 0; i < 3; i++) begin
            count_r[i]  <= CNT_ZERO;
            reload_r[i] <= CNT_ZERO;
            mode_r[i]   <= MODE_STOP;
         end
      end else begin
         clk_d_r       <= tick_src_s;
         out_r         <= out_nxt_s;
         rd_sel_r      <= rd_sel_nxt_s;
         counter_out_r <= read_val_s;
         for (int i = 0; i < 3; i++) begin
            count_r[i]  <= count_nxt_s[i];
            reload_r[i] <= reload_nxt_s[i];
            mode_r[i]   <= mode_nxt_s[i];
         end
      end
   end

`ifdef COUNTER_LATCH_EN
   // Snapshot registers: captured on a control write with val[31]=1.
   always_ff @(posedge clk) begin
      if (!RSTN) begin
         latched_r <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            latch_r[i] <= CNT_ZERO;
         end
      end else if (ctrl_wr_s) begin
         latched_r <= counter_val[31];
         for (int i = 0; i < 3; i++) begin
            latch_r[i] <= counter_val[31] ? count_r[i] : latch_r[i];
         end
      end else begin
         latched_r <= latched_r;
         for (int i = 0; i < 3; i++) begin
            latch_r[i] <= latch_r[i];
         end
      end
   end
`endif

   assign counter0_OUT = out_r[0];
   assign counter1_OUT = out_r[1];
   assign counter2_OUT = out_r[2];
   assign counter_out  = counter_out_r;

endmodule

// File: tb/tb_counter_timer3.sv
// -----------------------------------------------------------------------------
// tb_counter_timer3 -- directed self-checking bench for counter_timer3.
// Inputs change 1 time unit after a rising clk edge and outputs are checked
// at that same point, so every check sees the state produced by that edge.
// -----------------------------------------------------------------------------
module tb_counter_timer3;

   logic        clk = 1'b0;
   logic        RSTN;
   logic        clk0, clk1, clk2;
   logic        counter_we;
   logic [1:0]  counter_ch;
   logic [31:0] counter_val;
   logic        counter0_OUT, counter1_OUT, counter2_OUT;
   logic [31:0] counter_out;

   int vectors = 0;
   int errors  = 0;
   int pulses  = 0;

   counter_timer3 #(.WIDTH(32)) dut (
      .clk          (clk),
      .RSTN         (RSTN),
      .clk0         (clk0),
      .clk1         (clk1),
      .clk2         (clk2),
      .counter_we   (counter_we),
      .counter_ch   (counter_ch),
      .counter_val  (counter_val),
      .counter0_OUT (counter0_OUT),
      .counter1_OUT (counter1_OUT),
      .counter2_OUT (counter2_OUT),
      .counter_out  (counter_out)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] ch, input logic [31:0] val);
      counter_we  = 1'b1;
      counter_ch  = ch;
      counter_val = val;
      step();
      counter_we  = 1'b0;
      counter_val = 32'h0;
   endtask

   task automatic set_src(input int ch, input logic lvl);
      case (ch)
         0:       clk0 = lvl;
         1:       clk1 = lvl;
         default: clk2 = lvl;
      endcase
   endtask

   // One full tick: rise (count updates), then fall (readback catches up).
   task automatic pulse(input int ch);
      set_src(ch, 1'b1);
      step();
      set_src(ch, 1'b0);
      step();
   endtask

   initial begin
      RSTN = 1'b0; clk0 = 1'b0; clk1 = 1'b0; clk2 = 1'b0;
      counter_we = 1'b0; counter_ch = 2'd0; counter_val = 32'h0;

      // 1. Reset, then ticks with every channel stopped
      step(); step();
      chk("rst_out0", {31'h0, counter0_OUT}, 32'h0);
      chk("rst_out1", {31'h0, counter1_OUT}, 32'h0);
      chk("rst_out2", {31'h0, counter2_OUT}, 32'h0);
      chk("rst_cnt", counter_out, 32'h0);
      RSTN = 1'b1;
      step();
      for (int k = 0; k < 3; k++) begin
         pulse(0); pulse(1); pulse(2);
      end
      chk("stop_cnt", counter_out, 32'h0);
      chk("stop_outs", {29'h0, counter2_OUT, counter1_OUT, counter0_OUT}, 32'h0);

      // 2. ONE-SHOT on channel 0
      wr(2'd3, 32'h000);
      wr(2'd0, 32'd5);
      for (int k = 1; k <= 4; k++) begin
         pulse(0);
         chk("os_cnt", counter_out, 32'(5 - k));
      end
      chk("os_out_pre", {31'h0, counter0_OUT}, 32'h0);
      pulse(0);
      chk("os_cnt_zero", counter_out, 32'h0);
      chk("os_out_set", {31'h0, counter0_OUT}, 32'h1);
      for (int k = 0; k < 3; k++) begin
         pulse(0);
         chk("os_out_hold", {31'h0, counter0_OUT}, 32'h1);
      end
      chk("os_cnt_hold", counter_out, 32'h0);
      wr(2'd0, 32'd2);
      chk("os_out_clr", {31'h0, counter0_OUT}, 32'h0);

      // 3. RATE on channel 1 (channel 0 zeroed so readback is 0)
      wr(2'd3, 32'h004);
      wr(2'd0, 32'd0);
      wr(2'd1, 32'd3);
      for (int k = 1; k <= 12; k++) begin
         clk1 = 1'b1;
         step();
         chk("rate_pulse", {31'h0, counter1_OUT}, (k % 3 == 0) ? 32'h1 : 32'h0);
         if (counter1_OUT === 1'b1) pulses++;
         clk1 = 1'b0;
         step();
         chk("rate_clr", {31'h0, counter1_OUT}, 32'h0);
      end
      chk("rate_npulse", 32'(pulses), 32'd4);
      chk("rate_rd", counter_out, 32'h0);

      // 4. SQUARE on channel 2, readback of channel 2
      wr(2'd3, 32'h220);
      wr(2'd2, 32'd4);
      step();
      chk("sq_load", counter_out, 32'd4);
      for (int k = 1; k <= 8; k++) begin
         clk2 = 1'b1;
         step();
         if (k == 1) chk("sq_rd_lat", counter_out, 32'd4);
         clk2 = 1'b0;
         step();
         chk("sq_cnt", counter_out, (k % 4 == 0) ? 32'd4 : 32'(4 - (k % 4)));
         chk("sq_out", {31'h0, counter2_OUT}, (k >= 4 && k < 8) ? 32'h1 : 32'h0);
      end

      // 5. Write colliding with a tick on channel 0
      wr(2'd3, 32'h000);
      wr(2'd0, 32'd3);
      counter_we = 1'b1; counter_ch = 2'd0; counter_val = 32'd7; clk0 = 1'b1;
      step();
      counter_we = 1'b0; counter_val = 32'h0; clk0 = 1'b0;
      step();
      chk("coll_wr_wins", counter_out, 32'd7);
      pulse(0);
      chk("coll_next", counter_out, 32'd6);

      // 6a. Reset in the middle of a SQUARE count
      wr(2'd3, 32'h220);
      wr(2'd2, 32'd9);
      pulse(2); pulse(2);
      chk("mid_cnt", counter_out, 32'd7);
      clk2 = 1'b1; RSTN = 1'b0;
      step();
      chk("mid_rst_cnt", counter_out, 32'h0);
      chk("mid_rst_outs", {29'h0, counter2_OUT, counter1_OUT, counter0_OUT}, 32'h0);
      clk2 = 1'b0; RSTN = 1'b1;
      step();
      wr(2'd3, 32'h200);
      step();
      chk("mid_rst_ch2", counter_out, 32'h0);

      // 6b. Readback snapshot (live readback when the feature is absent)
      wr(2'd3, 32'h100);
      wr(2'd1, 32'd10);
      for (int k = 0; k < 4; k++) pulse(1);
      chk("lat_pre", counter_out, 32'd6);
      wr(2'd3, 32'h8000_0100);
      pulse(1); pulse(1);
`ifdef COUNTER_LATCH_EN
      chk("lat_held", counter_out, 32'd6);
`else
      chk("lat_live", counter_out, 32'd4);
`endif
      wr(2'd3, 32'h100);
      step();
      chk("lat_release", counter_out, 32'd4);

      // rd_sel=3 aliases channel 0; full-scale load decrements normally
      wr(2'd0, 32'hFFFF_FFFF);
      wr(2'd3, 32'h300);
      step();
      chk("rdsel3_max", counter_out, 32'hFFFF_FFFF);
      pulse(0);
      chk("max_dec", counter_out, 32'hFFFF_FFFE);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
